// File: rtl/trdb_stream_mux.sv
// trdb_stream_mux: merges trace packets and framed software words into one stream, with flush handshake
module trdb_stream_mux #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned SEQ_WIDTH    = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] packet_word_i,
   input  logic        packet_valid_i,
   output logic        packet_grant_o,
   input  logic [31:0] sw_word_i,
   input  logic        sw_valid_i,
   output logic        sw_grant_o,
   input  logic        flush_i,
   output logic        flush_confirm_o,
   output logic [31:0] stream_word_o,
   output logic        stream_valid_o,
   input  logic        stream_ready_i
);
   typedef enum logic [2:0] {ARB, SW_PAYLOAD, FLUSH_MARK, FLUSH_WAIT, FLUSH_DONE} state_e;
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   state_e state_q, state_d;
   logic [SEQ_WIDTH-1:0] seq_q;
   logic [7:0] starve_q;
   logic slot_free, starved, load;
   logic [31:0] load_word;
   assign slot_free = ~stream_valid_o | stream_ready_i;
   assign starved = starve_q >= LIMIT;
   // grants are masked by reset so a pending header/payload pair is abandoned cleanly
   always_comb begin
      state_d = state_q;
      packet_grant_o = 1'b0;
      sw_grant_o = 1'b0;
      load = 1'b0;
      load_word = packet_word_i;
      case (state_q)
         ARB: if (slot_free) begin
            if (packet_valid_i && !starved) begin
               packet_grant_o = rst_ni;
               load = 1'b1;
            end else if (sw_valid_i) begin
               load = 1'b1;
               load_word = {4'hF, 12'h000, 16'(seq_q)};
               state_d = SW_PAYLOAD;
            end else if (flush_i) state_d = FLUSH_MARK;
         end
         SW_PAYLOAD: if (slot_free) begin
            load = 1'b1;
            load_word = sw_word_i;
            sw_grant_o = rst_ni;
            state_d = ARB;
         end
         FLUSH_MARK: if (slot_free) begin
            load = 1'b1;
            load_word = 32'hE000_0000;
            state_d = FLUSH_WAIT;
         end
         FLUSH_WAIT: state_d = (stream_valid_o && stream_ready_i) ? FLUSH_DONE : FLUSH_WAIT;
         FLUSH_DONE: state_d = flush_i ? FLUSH_DONE : ARB;
         default: state_d = ARB;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ARB;
         stream_word_o <= '0;
         stream_valid_o <= 1'b0;
         flush_confirm_o <= 1'b0;
         seq_q <= '0;
         starve_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            stream_word_o <= load_word;
            stream_valid_o <= 1'b1;
         end else if (stream_ready_i) stream_valid_o <= 1'b0;
         flush_confirm_o <= (state_q == FLUSH_WAIT) && stream_valid_o && stream_ready_i;
         if (sw_grant_o) begin
            seq_q <= seq_q + 1'b1;
            starve_q <= '0;
         end else if (packet_grant_o && sw_valid_i && !starved) starve_q <= starve_q + 8'd1;
      end
   end
endmodule

// File: doc/trdb_stream_mux.md
# trdb_stream_mux

Output-side arbiter of the trace debugger. It merges encoded trace packet words with software dump words drained from the software FIFO into a single 32-bit word stream toward the trace sink. It also executes the stream-flush handshake requested by the control register.
- Trace packets have priority over software words.
- Software words are framed with a header word.
- A starvation limit guarantees software progress.

## Interface
Parameters:
- STARVE_LIMIT, default 8: consecutive packet words accepted while a software word waits before software is forced one slot; range 1..255.
- SEQ_WIDTH, default 16: width of the software sequence counter carried in headers; range 1..16.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- packet_word_i  in  32  trace packet word.
- packet_valid_i  in  1  packet word valid.
- packet_grant_o  out  1  packet word consumed this cycle.
- sw_word_i  in  32  software dump word, from the software FIFO head.
- sw_valid_i  in  1  software word valid.
- sw_grant_o  out  1  software word consumed this cycle.
- flush_i  in  1  flush request, level; held high until confirmed.
- flush_confirm_o  out  1  one-cycle pulse, flush complete.
- stream_word_o  out  32  output word.
- stream_valid_o  out  1  output word valid.
- stream_ready_i  in  1  sink accepts the output word.

## Operation
- Single output register (word+valid). Slot free = ~stream_valid_o | stream_ready_i. At most one word is loaded per cycle, and only when the slot is free.
- Source valids must stay asserted with stable data until granted. A grant is combinational: same cycle as the load.
- SW header word = {4'hF, 12'h000, seq} (seq zero-extended to 16 bits). Flush marker = 32'hE000_0000. Packet words pass through unmodified.
- seq: SEQ_WIDTH-bit counter, +1 per software payload granted, wraps to 0.
- starve_cnt: 8-bit counter.
  - +1 on each packet grant while sw_valid_i=1.
  - Cleared on a software payload grant.
  - Saturates at STARVE_LIMIT.
- FSM states:
  - ARB, when slot free:
    - If packet_valid_i and starve_cnt<STARVE_LIMIT: load packet, packet_grant_o=1.
    - Else if sw_valid_i: load header, go SW_PAYLOAD. No grant yet.
    - Else if flush_i: go FLUSH_MARK.
    - In ARB, flush_i is considered only when both inputs are idle, so the stream drains before the marker.
  - SW_PAYLOAD: when slot free, load sw_word_i, sw_grant_o=1, seq++, starve_cnt=0, go ARB. Packets are never granted between header and payload.
  - FLUSH_MARK: when slot free, load marker, go FLUSH_WAIT. No input is granted.
  - FLUSH_WAIT: when stream_valid_o & stream_ready_i (marker accepted), pulse flush_confirm_o, go FLUSH_DONE.
  - FLUSH_DONE: no grants; when flush_i=0, go ARB.
- No grant is issued in FLUSH_MARK, FLUSH_WAIT or FLUSH_DONE. Inputs arriving there wait.

## Timing
- Reset values:
  - stream_word_o=0, stream_valid_o=0.
  - Grants 0, flush_confirm_o=0.
  - seq=0, starve_cnt=0, state ARB.
- Reset mid-operation abandons any pending header/payload pair with no grant issued.
- Latency: input grant cycle N means the word is on stream_word_o from cycle N+1.
- Full throughput: with stream_ready_i held 1, one word per cycle. A software word costs 2 cycles.
- Backpressure: when stream_ready_i=0 and stream_valid_o=1, the output word and valid hold stable and no grants are issued.
- stream_valid_o deasserts the cycle after acceptance if nothing new was loaded.
- flush_confirm_o is asserted exactly one cycle, in the cycle after marker acceptance.
- flush_i falling one cycle after confirm is the expected case. If flush_i stays high, the block remains in FLUSH_DONE.
- Simultaneous packet and software valid with starve_cnt<STARVE_LIMIT: the packet wins. With starve_cnt==STARVE_LIMIT: software wins.

## Test plan
- Reset, then packet_valid_i with words 0x11..0x13, ready=1. Required: grants in cycles 1-3, stream shows 0x11,0x12,0x13 in cycles 2-4, valid drops in cycle 5.
- Single software word 0xDEADBEEF, no packets. Required: stream shows 0xF0000000 then 0xDEADBEEF. sw_grant_o fires in the payload cycle only. The next header carries seq=1.
- Packets continuously valid, software valid, STARVE_LIMIT=8. Required: 8 packet words, then header+payload, then packets resume. starve_cnt returns to 0.
- ready=0 for 5 cycles while a header is in the output register. Required: header held stable, no grants, payload follows immediately after ready rises.
- flush_i raised with 2 packets and 1 software word pending. Required: all drain, then 0xE0000000, then a single-cycle flush_confirm_o after marker acceptance. No grants until flush_i=0.
- SEQ_WIDTH=2, 5 software words. Required: header seq fields 0,1,2,3,0 (wrap-around).
